// File: rtl/param_universal_shift_register.sv
// ---------------------------------------------------------------------------
// param_universal_shift_register
//
// WIDTH-bit universal shift register with single-step operations (hold,
// logical shifts, load, rotates, arithmetic shift right, clear) and a
// multi-step burst mode driven by a small IDLE/RUN FSM.
//
// Ports:
//   clk       rising-edge clock for all state
//   rst_n     synchronous active-low reset (acts regardless of ena)
//   ena       clock enable; no state change when low (done still clears)
//   mode      3-bit operation select
//   start     burst request, sampled while IDLE
//   sin_l     serial bit entering the LSB on shift-left
//   sin_r     serial bit entering the MSB on logical shift-right
//   d         parallel load data
//   shamt     burst step count
//   q         register state
//   sout_msb  q[WIDTH-1]
//   sout_lsb  q[0]
//   busy      high while the burst FSM is in RUN
//   done      one-cycle pulse after a burst completes
// ---------------------------------------------------------------------------
module param_universal_shift_register #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [2:0]         mode,
  input  logic               start,
  input  logic               sin_l,
  input  logic               sin_r,
  input  logic [WIDTH-1:0]   d,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   q,
  output logic               sout_msb,
  output logic               sout_lsb,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHR   = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROR   = 3'b100;
  localparam logic [2:0] M_ROL   = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [SHAMT_W-1:0] cnt_reg;
  logic [2:0]         mode_r_reg;
  logic               done_reg;

  // One step of the selected operation applied to value v.
  function automatic logic [WIDTH-1:0] step_fn(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] load_val,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    r = v;
    case (m)
      M_HOLD:  r = v;
      M_SHR:   r = {sr, v[WIDTH-1:1]};
      M_SHL:   r = {v[WIDTH-2:0], sl};
      M_LOAD:  r = load_val;
      M_ROR:   r = {v[0], v[WIDTH-1:1]};
      M_ROL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
      M_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
      M_CLEAR: r = '0;
      default: r = v;
    endcase
    return r;
  endfunction

  // Only the shift/rotate modes make sense repeated; hold, load and clear
  // are idempotent so a start with them is treated as a plain single step.
  function automatic logic burst_ok(input logic [2:0] m);
    return (m == M_SHR) || (m == M_SHL) || (m == M_ROR) ||
           (m == M_ROL) || (m == M_ASR);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      q_reg      <= '0;
      cnt_reg    <= '0;
      mode_r_reg <= M_HOLD;
      done_reg   <= 1'b0;
    end else begin
      // done is a pulse: it always drops after one cycle, even with ena low.
      done_reg <= 1'b0;
      if (ena) begin
        case (state_reg)
          IDLE: begin
            if (start && burst_ok(mode)) begin
              // q is untouched on the accept edge; steps begin next edge.
              mode_r_reg <= mode;
              cnt_reg    <= shamt;
              if (shamt == '0) begin
                done_reg <= 1'b1;
              end else begin
                state_reg <= RUN;
              end
            end else begin
              q_reg <= step_fn(mode, q_reg, d, sin_l, sin_r);
            end
          end
          RUN: begin
            // Serial inputs are sampled live so bursts can stream data.
            q_reg   <= step_fn(mode_r_reg, q_reg, d, sin_l, sin_r);
            cnt_reg <= cnt_reg - SHAMT_W'(1);
            if (cnt_reg == SHAMT_W'(1)) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign q        = q_reg;
  assign sout_msb = q_reg[WIDTH-1];
  assign sout_lsb = q_reg[0];
  assign busy     = (state_reg == RUN);
  assign done     = done_reg;

endmodule

// File: tb/tb_param_universal_shift_register.sv
module tb_param_universal_shift_register;

  localparam int WIDTH   = 8;
  localparam int SHAMT_W = 4;
  localparam int MASK    = (1 << WIDTH) - 1;

  logic               clk;
  logic               rst_n;
  logic               ena;
  logic [2:0]         mode;
  logic               start;
  logic               sin_l;
  logic               sin_r;
  logic [WIDTH-1:0]   d;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   q;
  logic               sout_msb;
  logic               sout_lsb;
  logic               busy;
  logic               done;

  param_universal_shift_register #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .start(start),
    .sin_l(sin_l), .sin_r(sin_r), .d(d), .shamt(shamt), .q(q),
    .sout_msb(sout_msb), .sout_lsb(sout_lsb), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("check %s: 0x%0h ok", name, act);
    end
  endtask

  // ---------------- behavioural model ----------------
  // q as an integer; a burst is "remaining steps" plus the latched op.
  int m_q, m_left, m_mode;
  bit m_busy, m_done, m_valid;

  function automatic int apply(input int op, input int v, input int ld,
                               input int sl, input int sr);
    case (op)
      1: return (v >> 1) | (sr << (WIDTH - 1));
      2: return ((v << 1) | sl) & MASK;
      3: return ld & MASK;
      4: return (v >> 1) | ((v & 1) << (WIDTH - 1));
      5: return ((v << 1) | (v >> (WIDTH - 1))) & MASK;
      6: return (v >> 1) | (v & (1 << (WIDTH - 1)));
      7: return 0;
      default: return v;
    endcase
  endfunction

  initial begin
    m_q = 0; m_left = 0; m_mode = 0; m_busy = 0; m_done = 0; m_valid = 0;
  end

  always @(posedge clk) begin
    int nq, nleft, nmode;
    bit nbusy, ndone;
    nq = m_q; nleft = m_left; nmode = m_mode; nbusy = m_busy; ndone = 0;
    if (!rst_n) begin
      nq = 0; nleft = 0; nmode = 0; nbusy = 0;
    end else if (ena) begin
      if (m_busy) begin
        nq = apply(m_mode, m_q, d, sin_l, sin_r);
        nleft = m_left - 1;
        if (nleft == 0) begin nbusy = 0; ndone = 1; end
      end else if (start && (mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6})) begin
        nmode = mode;
        nleft = shamt;
        if (shamt == 0) ndone = 1; else nbusy = 1;
      end else begin
        nq = apply(mode, m_q, d, sin_l, sin_r);
      end
    end
    m_q <= nq; m_left <= nleft; m_mode <= nmode; m_busy <= nbusy; m_done <= ndone;
    if (!rst_n) m_valid <= 1'b1;
  end

  // Per-cycle comparison plus pulse/busy counters for scenario windows.
  int busy_cycles = 0;
  int done_pulses = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      n_cmp++;
      if (q !== m_q[WIDTH-1:0] || sout_msb !== m_q[WIDTH-1] ||
          sout_lsb !== m_q[0] || busy !== m_busy || done !== m_done) begin
        n_err++;
        $display("FAIL model_cmp t=%0t: q=%h msb=%b lsb=%b busy=%b done=%b, expected q=%h busy=%b done=%b",
                 $time, q, sout_msb, sout_lsb, busy, done,
                 m_q[WIDTH-1:0], m_busy, m_done);
      end
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) done_pulses++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    mode = 3'd3; d = v; start = 0;
    cyc(1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 0; ena = 0; mode = 0; start = 0; sin_l = 0; sin_r = 0;
    d = '0; shamt = '0;
    cyc(2);
    check("reset_q", q, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst_n = 1; ena = 1;

    load(8'hA5);                 check("load_a5", q, 'hA5);
    mode = 3'd1; sin_r = 1; cyc(1); check("shr_sin1", q, 'hD2);
    check("sout_msb", sout_msb, 1);
    mode = 3'd2; sin_l = 0; cyc(1); check("shl_sin0", q, 'hA4);
    mode = 3'd7; cyc(1);            check("clear", q, 0);

    load(8'h81); mode = 3'd4; cyc(1); check("ror_81", q, 'hC0);
    load(8'h81); mode = 3'd5; cyc(1); check("rol_81", q, 'h03);
    load(8'h80); mode = 3'd6; cyc(3); check("asr3_80", q, 'hF0);

    // ena low in IDLE: nothing moves.
    ena = 0; mode = 3'd7; cyc(2); check("ena_low_hold", q, 'hF0);
    ena = 1;

    // ROL burst by full width returns the original; mode churn is ignored.
    load(8'h96);
    busy_cycles = 0; done_pulses = 0;
    mode = 3'd5; shamt = 4'd8; start = 1; cyc(1);
    start = 0;
    check("rol_accept_q", q, 'h96);
    for (int i = 0; i < 8; i++) begin
      mode = 3'($urandom_range(0, 7));
      cyc(1);
    end
    mode = 3'd0;
    check("rol8_q", q, 'h96);
    check("rol8_done", done, 1);
    cyc(1);
    check("rol8_busy_cycles", busy_cycles, 8);
    check("rol8_done_pulses", done_pulses, 1);

    // SHL burst with a 2-cycle ena pause.
    load(8'h01);
    busy_cycles = 0; done_pulses = 0;
    mode = 3'd2; sin_l = 0; shamt = 4'd4; start = 1; cyc(1);
    start = 0; mode = 3'd0;
    cyc(2);
    ena = 0; cyc(2); check("pause_q", q, 'h04);
    check("pause_busy", busy, 1);
    ena = 1; cyc(2);
    check("shl4_q", q, 'h10);
    cyc(1);
    check("shl4_busy_cycles", busy_cycles, 6);
    check("shl4_done_pulses", done_pulses, 1);

    // shamt = 0: immediate done, no busy, q unchanged.
    busy_cycles = 0;
    mode = 3'd1; shamt = 4'd0; start = 1; cyc(1);
    start = 0; mode = 3'd0;
    check("shamt0_q", q, 'h10);
    check("shamt0_done", done, 1);
    cyc(1);
    check("shamt0_done_clear", done, 0);
    check("shamt0_busy_cycles", busy_cycles, 0);

    // start with LOAD is a plain load.
    mode = 3'd3; d = 8'h3C; start = 1; shamt = 4'd5; cyc(1);
    start = 0; mode = 3'd0;
    check("start_load_q", q, 'h3C);
    check("start_load_busy", busy, 0);

    // SHR burst aborted by reset at step 3.
    load(8'hFF);
    done_pulses = 0;
    mode = 3'd1; sin_r = 0; shamt = 4'd5; start = 1; cyc(1);
    start = 0; mode = 3'd0;
    cyc(2); check("abort_mid_q", q, 'h3F);
    rst_n = 0; cyc(1); rst_n = 1;
    check("abort_q", q, 0);
    check("abort_busy", busy, 0);
    cyc(3);
    check("abort_done_pulses", done_pulses, 0);

    // A new burst completes normally, then a start in the done cycle.
    load(8'h0F);
    mode = 3'd2; sin_l = 1; shamt = 4'd3; start = 1; cyc(1);
    start = 0; mode = 3'd0;
    cyc(3);
    check("reburst_q", q, 'h7F);
    check("reburst_done", done, 1);
    mode = 3'd6; shamt = 4'd9; start = 1; cyc(1);
    start = 0; mode = 3'd0;
    check("back2back_busy", busy, 1);
    cyc(9);
    check("asr_sat_q", q, 'h00);

    load(8'h80);
    mode = 3'd6; shamt = 4'd9; start = 1; cyc(1);
    start = 0; mode = 3'd0;
    cyc(9);
    check("asr_sat_neg_q", q, 'hFF);
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
